instr_fetch_unit: RTL and testbench

Fetch-side reader for the 8-bit instruction memory. It owns the program counter and drives the memory's combinational read address. It captures the returned instruction byte into an output register and presents it, pre-split into fields, to the decode stage over a valid/ready handshake. It also accepts PC redirects (branch/jump resolution) from the execute stage and squashes any stale fetched instruction.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction memory combinationally,
// and hands instruction bytes to decode over a valid/ready output register.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [7:0]        instruction,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [7:0]        out_instr,
    output logic [1:0]        out_op,
    output logic [1:0]        out_rs,
    output logic [1:0]        out_rt,
    output logic [1:0]        out_rd,
    output logic [7:0]        out_imm,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [7:0]         out_instr_q, out_instr_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

    logic load;
    logic transfer;

    assign load     = (state_q == RUN) && en && (!out_valid_q || out_ready) && !redirect;
    assign transfer = out_valid_q && out_ready;

    always_comb begin
        state_d       = en ? RUN : IDLE;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        fetch_count_d = fetch_count_q;

        // A transfer coincident with a redirect was already accepted, so it still counts.
        if (transfer && (fetch_count_q != {CNT_W{1'b1}})) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end

        if (redirect) begin
            pc_d        = redirect_addr;
            out_valid_d = 1'b0;
        end else if (load) begin
            out_instr_d = instruction;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = (pc_q == LAST_PC) ? RESET_PC_V : pc_q + ADDR_W'(1);
        end else if (transfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC_V;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Read_Address = pc_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign fetch_count  = fetch_count_q;

    assign out_op  = out_instr_q[7:6];
    assign out_rs  = out_instr_q[5:4];
    assign out_rt  = out_instr_q[3:2];
    assign out_rd  = out_instr_q[1:0];
    assign out_imm = {{6{out_instr_q[1]}}, out_instr_q[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a small instruction memory model.
module tb_instr_fetch_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    Read_Address;
    logic [7:0]    instruction;
    logic          redirect;
    logic [7:0]    redirect_addr;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pc;
    logic [7:0]    out_instr;
    logic [1:0]    out_op, out_rs, out_rt, out_rd;
    logic [7:0]    out_imm;
    logic [CW-1:0] fetch_count;

    logic [7:0] mem [256];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign instruction = mem[Read_Address];

    instr_fetch_unit #(
        .ADDR_W(8), .PROG_LEN(8), .RESET_PC(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Read_Address(Read_Address), .instruction(instruction),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_imm(out_imm), .fetch_count(fetch_count)
    );

    typedef struct {
        logic       en;
        logic       rdy;
        logic       redir;
        logic [7:0] raddr;
        logic       exp_valid;
        logic [7:0] exp_pc;
        logic [7:0] exp_instr;
        logic [7:0] exp_ra;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs [29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_fields(input logic [1:0] op, input logic [1:0] rs, input logic [1:0] rt,
                                input logic [1:0] rd, input logic [7:0] imm);
        check("out_op", 32'(out_op), 32'(op));
        check("out_rs", 32'(out_rs), 32'(rs));
        check("out_rt", 32'(out_rt), 32'(rt));
        check("out_rd", 32'(out_rd), 32'(rd));
        check("out_imm", 32'(out_imm), 32'(imm));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
        mem[0] = 8'h59; mem[1] = 8'h49; mem[2] = 8'hC1; mem[3] = 8'h18;
        mem[4] = 8'h33; mem[5] = 8'h77; mem[6] = 8'hAE; mem[7] = 8'h05;

        //          en rdy rd raddr  vld pc  instr  ra   cnt
        vecs[0]  = '{1, 1, 0, 8'd0,   0, 8'd0,   8'h00, 8'd0,   4'd0};
        vecs[1]  = '{1, 1, 0, 8'd0,   1, 8'd0,   8'h59, 8'd1,   4'd0};
        vecs[2]  = '{1, 1, 0, 8'd0,   1, 8'd1,   8'h49, 8'd2,   4'd1};
        vecs[3]  = '{1, 0, 0, 8'd0,   1, 8'd1,   8'h49, 8'd2,   4'd1};
        vecs[4]  = '{1, 0, 0, 8'd0,   1, 8'd1,   8'h49, 8'd2,   4'd1};
        vecs[5]  = '{1, 0, 0, 8'd0,   1, 8'd1,   8'h49, 8'd2,   4'd1};
        vecs[6]  = '{1, 1, 0, 8'd0,   1, 8'd2,   8'hC1, 8'd3,   4'd2};
        vecs[7]  = '{1, 1, 0, 8'd0,   1, 8'd3,   8'h18, 8'd4,   4'd3};
        vecs[8]  = '{1, 1, 0, 8'd0,   1, 8'd4,   8'h33, 8'd5,   4'd4};
        vecs[9]  = '{1, 1, 0, 8'd0,   1, 8'd5,   8'h77, 8'd6,   4'd5};
        vecs[10] = '{1, 1, 0, 8'd0,   1, 8'd6,   8'hAE, 8'd7,   4'd6};
        vecs[11] = '{1, 1, 0, 8'd0,   1, 8'd7,   8'h05, 8'd0,   4'd7};
        vecs[12] = '{1, 1, 0, 8'd0,   1, 8'd0,   8'h59, 8'd1,   4'd8};
        vecs[13] = '{1, 1, 0, 8'd0,   1, 8'd1,   8'h49, 8'd2,   4'd9};
        vecs[14] = '{1, 0, 1, 8'd5,   0, 8'd1,   8'h49, 8'd5,   4'd9};
        vecs[15] = '{1, 1, 0, 8'd0,   1, 8'd5,   8'h77, 8'd6,   4'd9};
        vecs[16] = '{0, 1, 0, 8'd0,   0, 8'd5,   8'h77, 8'd6,   4'd10};
        vecs[17] = '{0, 1, 0, 8'd0,   0, 8'd5,   8'h77, 8'd6,   4'd10};
        vecs[18] = '{1, 1, 0, 8'd0,   0, 8'd5,   8'h77, 8'd6,   4'd10};
        vecs[19] = '{1, 1, 0, 8'd0,   1, 8'd6,   8'hAE, 8'd7,   4'd10};
        vecs[20] = '{1, 1, 0, 8'd0,   1, 8'd7,   8'h05, 8'd0,   4'd11};
        vecs[21] = '{1, 1, 1, 8'd2,   0, 8'd7,   8'h05, 8'd2,   4'd12};
        vecs[22] = '{1, 1, 1, 8'd200, 0, 8'd7,   8'h05, 8'd200, 4'd12};
        vecs[23] = '{1, 1, 0, 8'd0,   1, 8'd200, 8'h6D, 8'd201, 4'd12};
        vecs[24] = '{1, 1, 0, 8'd0,   1, 8'd201, 8'h6C, 8'd202, 4'd13};
        vecs[25] = '{0, 0, 1, 8'd7,   0, 8'd201, 8'h6C, 8'd7,   4'd13};
        vecs[26] = '{1, 1, 0, 8'd0,   0, 8'd201, 8'h6C, 8'd7,   4'd13};
        vecs[27] = '{1, 1, 0, 8'd0,   1, 8'd7,   8'h05, 8'd0,   4'd13};
        vecs[28] = '{1, 1, 0, 8'd0,   1, 8'd0,   8'h59, 8'd1,   4'd14};

        rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = 8'd0;
        #1;
        check("reset_read_address", 32'(Read_Address), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_out_pc", 32'(out_pc), 32'd0);
        check("reset_instr", 32'(out_instr), 32'd0);
        check("reset_count", 32'(fetch_count), 32'd0);
        check_fields(2'd0, 2'd0, 2'd0, 2'd0, 8'h00);

        for (int i = 0; i < 29; i++) begin
            en = vecs[i].en; out_ready = vecs[i].rdy;
            redirect = vecs[i].redir; redirect_addr = vecs[i].raddr;
            @(posedge clk);
            #1;
            $display("vec %0d: en=%0d rdy=%0d redir=%0d -> valid=%0d pc=%0d instr=%02h ra=%0d cnt=%0d",
                     i, en, out_ready, redirect, out_valid, out_pc, out_instr, Read_Address, fetch_count);
            check("out_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
            check("out_pc", 32'(out_pc), 32'(vecs[i].exp_pc));
            check("out_instr", 32'(out_instr), 32'(vecs[i].exp_instr));
            check("read_address", 32'(Read_Address), 32'(vecs[i].exp_ra));
            check("fetch_count", 32'(fetch_count), 32'(vecs[i].exp_cnt));
            if (i == 1)  check_fields(2'd1, 2'd1, 2'd2, 2'd1, 8'h01);
            if (i == 7)  check_fields(2'd0, 2'd1, 2'd2, 2'd0, 8'h00);
            if (i == 10) check_fields(2'd2, 2'd2, 2'd3, 2'd2, 8'hFE);
        end

        // Asynchronous reset pulse between edges while streaming.
        en = 1'b1; out_ready = 1'b1; redirect = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("async reset: valid=%0d ra=%0d cnt=%0d", out_valid, Read_Address, fetch_count);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ra", 32'(Read_Address), 32'd0);
        check("async_rst_count", 32'(fetch_count), 32'd0);
        check("async_rst_instr", 32'(out_instr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset: one edge to enter RUN, one to load address 0.
        @(posedge clk); #1;
        check("restart_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        $display("restart: valid=%0d pc=%0d instr=%02h", out_valid, out_pc, out_instr);
        check("restart_valid", 32'(out_valid), 32'd1);
        check("restart_instr", 32'(out_instr), 32'h59);
        check("restart_pc", 32'(out_pc), 32'd0);

        // Counter saturation at all-ones (CNT_W=4).
        repeat (18) @(posedge clk);
        #1;
        $display("saturate: cnt=%0d", fetch_count);
        check("count_saturated", 32'(fetch_count), 32'd15);
        @(posedge clk); #1;
        check("count_stays_saturated", 32'(fetch_count), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
